main_memory_arbiter: RTL
========================

Name: main_memory_arbiter

Overview:
Parametrised single-port main-memory front end shared by the instruction-fetch and data (load/store) paths of the CPU. It accepts requests from two clients, arbitrates between them, and drives one request/acknowledge transaction at a time to a variable-latency memory. It returns read data to the owning client and flags transactions that time out. Configurable width, byte strobes, fetch anti-starvation and a memory timeout are new relative to the fixed single-cycle stage mux it replaces.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; must be a multiple of 8
STARVE_LIMIT, 4, consecutive IDLE-state losses to the data client after which fetch wins; 0 = strict data priority
TIMEOUT_CYCLES, 64, maximum BUSY cycles waiting for mem_ack; 0 = no timeout

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch read request, held until fetch_gnt
fetch_addr  in  ADDR_WIDTH  fetch address (PC)
fetch_gnt  out  1  combinational: fetch request accepted this cycle
fetch_rvalid  out  1  one-cycle pulse: fetch_rdata valid
fetch_rdata  out  DATA_WIDTH  fetched instruction word
data_req  in  1  load/store request, held until data_gnt
data_we  in  1  1 = store, 0 = load
data_be  in  DATA_WIDTH/8  store byte enables
data_addr  in  ADDR_WIDTH  load/store address
data_wdata  in  DATA_WIDTH  store data
data_gnt  out  1  combinational: data request accepted this cycle
data_rvalid  out  1  one-cycle pulse: load data valid or store complete
data_rdata  out  DATA_WIDTH  load data
mem_req  out  1  registered: transaction outstanding to memory
mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_WIDTH/8/ADDR_WIDTH/DATA_WIDTH  registered copy of the granted request
mem_ack  in  1  memory completes the transaction this cycle
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
resp_err  out  1  pulse coincident with rvalid when the transaction timed out
err_sticky  out  1  set on any timeout, cleared only by reset
busy  out  1  state is BUSY

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0, including the rdata, mem_* and error registers, the starvation counter and the timeout counter.
- States: IDLE and BUSY.
- IDLE, arbitration:
  - Grant goes to data if data_req, else to fetch if fetch_req.
  - Exception: if fetch_req and the starvation count has reached STARVE_LIMIT (STARVE_LIMIT≠0), fetch wins.
  - gnt is asserted for exactly the winning client in that cycle. The request fields are latched into mem_*, the owner is recorded, and the state goes to BUSY.
- Starvation count:
  - +1 in each IDLE cycle where fetch_req is high but data wins.
  - Cleared when fetch is granted or fetch_req is low.
  - Saturates at STARVE_LIMIT.
- Fetch grants force mem_we=0 and mem_be to all ones.
- In BUSY: mem_req=1, both gnt=0, and mem_* are held stable.
- On mem_ack in BUSY:
  - Next cycle: owner's rvalid=1 and owner's rdata=mem_rdata (loads and fetches only; a store leaves data_rdata unchanged).
  - mem_req drops, the state returns to IDLE, and the timeout counter clears.
- Latency: grant at cycle N, mem_req high from N+1, ack at cycle M, rvalid at M+1. A new grant is possible in the same cycle M+1, so back-to-back transactions have one idle mem_req cycle between them.
- Timeout (TIMEOUT_CYCLES≠0):
  - The counter increments each BUSY cycle without mem_ack.
  - If it reaches TIMEOUT_CYCLES without an ack, the transaction is abandoned:
    - next cycle: owner rvalid=1, resp_err=1, owner rdata all ones, err_sticky=1, state IDLE;
    - mem_req drops.
  - An mem_ack on the same cycle as the limit wins: normal response, no error.
- mem_ack in IDLE is ignored.
- rvalid, resp_err and gnt are never asserted for both clients at once.
- Reset during BUSY aborts the transaction with no response.

Test Plan:
- Single fetch, addr 0x100, mem_ack 3 cycles after mem_req, mem_rdata 0xDEADBEEF -> fetch_gnt at N, mem_req N+1..N+3, fetch_rvalid at N+4 with 0xDEADBEEF.
- Simultaneous fetch_req and data_req (store, be=4'b0011, wdata 0x1234ABCD) -> data granted first; mem_we=1, mem_be=0011; fetch granted on the IDLE cycle after data_rvalid.
- data_req held continuously with fetch_req, STARVE_LIMIT=4, immediate acks -> after 4 data wins, the fifth grant goes to fetch; the count then resets.
- TIMEOUT_CYCLES=8, no mem_ack -> rvalid and resp_err one cycle after 8 BUSY cycles, rdata 0xFFFFFFFF, err_sticky=1 until reset.
- mem_ack on exactly the timeout cycle -> normal response, resp_err=0, err_sticky unchanged.
- rst_n low mid-BUSY -> mem_req and all outputs 0 immediately, no rvalid; the first request after reset is serviced normally.

Source files
------------

// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if: fetch/data client and memory-side signals of the main memory arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface main_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    fetch_req;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    fetch_gnt;
    logic                    fetch_rvalid;
    logic [DATA_WIDTH-1:0]   fetch_rdata;
    logic                    data_req;
    logic                    data_we;
    logic [DATA_WIDTH/8-1:0] data_be;
    logic [ADDR_WIDTH-1:0]   data_addr;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic                    data_gnt;
    logic                    data_rvalid;
    logic [DATA_WIDTH-1:0]   data_rdata;
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ack;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    resp_err;
    logic                    err_sticky;
    logic                    busy;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_be, data_addr, data_wdata,
               mem_ack, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_err, err_sticky, busy
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_be, data_addr, data_wdata,
               mem_ack, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_err, err_sticky, busy
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: two-client (fetch/data) arbiter driving one req/ack transaction at a time
// to a variable-latency memory, with fetch anti-starvation and a response timeout.
module main_memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    main_memory_arbiter_if.slave bus
);
    localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic          owner_data;
    logic [SW-1:0] scnt;
    logic [TW-1:0] tcnt;
    logic          starve_hit, fetch_win, data_win, timeout;

    always_comb begin
        starve_hit = (STARVE_LIMIT != 0) && (scnt == SW'(STARVE_LIMIT));
        fetch_win  = (state == IDLE) && bus.fetch_req && (!bus.data_req || starve_hit);
        data_win   = (state == IDLE) && bus.data_req && !fetch_win;
        // An ack arriving on the limit cycle takes precedence over the timeout.
        timeout    = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !bus.mem_ack &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));
    end

    assign bus.fetch_gnt = fetch_win;
    assign bus.data_gnt  = data_win;
    assign bus.busy      = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            owner_data       <= 1'b0;
            scnt             <= '0;
            tcnt             <= '0;
            bus.fetch_rvalid <= 1'b0;
            bus.fetch_rdata  <= '0;
            bus.data_rvalid  <= 1'b0;
            bus.data_rdata   <= '0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_be       <= '0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.resp_err     <= 1'b0;
            bus.err_sticky   <= 1'b0;
        end else begin
            bus.fetch_rvalid <= 1'b0;
            bus.data_rvalid  <= 1'b0;
            bus.resp_err     <= 1'b0;
            if (!bus.fetch_req || fetch_win)
                scnt <= '0;
            else if (data_win && scnt != SW'(STARVE_LIMIT))
                scnt <= scnt + 1'b1;
            if (state == IDLE) begin
                if (fetch_win || data_win) begin
                    state         <= BUSY;
                    owner_data    <= data_win;
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= data_win && bus.data_we;
                    bus.mem_be    <= data_win ? bus.data_be : '1;
                    bus.mem_addr  <= data_win ? bus.data_addr : bus.fetch_addr;
                    bus.mem_wdata <= data_win ? bus.data_wdata : '0;
                end
            end else if (bus.mem_ack || timeout) begin
                state            <= IDLE;
                tcnt             <= '0;
                bus.mem_req      <= 1'b0;
                bus.fetch_rvalid <= !owner_data;
                bus.data_rvalid  <= owner_data;
                bus.resp_err     <= timeout;
                if (timeout)
                    bus.err_sticky <= 1'b1;
                if (!owner_data)
                    bus.fetch_rdata <= timeout ? '1 : bus.mem_rdata;
                else if (timeout || !bus.mem_we)
                    bus.data_rdata <= timeout ? '1 : bus.mem_rdata;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule
